// File: rtl/ctrl_sched_fsm.sv
// ctrl_sched_fsm: DDR scheduler FSM with tREFI timer, postponed refresh drain, paced bank activation and sticky MRS update.
module ctrl_sched_fsm #(
  parameter int NUM_BANKS    = 4,
  parameter int T_RRD        = 4,
  parameter int T_RCD        = 14,
  parameter int T_RFC        = 260,
  parameter int T_REFI       = 6240,
  parameter int T_MOD        = 24,
  parameter int MAX_POSTPONE = 8,
  parameter int CNT_W        = 16
) (
  input  logic                 CK_t,
  input  logic                 reset_n,
  input  logic                 ini_done,
  input  logic                 rw_req,
  input  logic                 rw_idle,
  input  logic                 mrs_update,
  output logic [2:0]           state,
  output logic                 busy,
  output logic                 rw_proc,
  output logic                 act_cmd,
  output logic [3:0]           act_bank,
  output logic [NUM_BANKS-1:0] bank_open,
  output logic                 ref_cmd,
  output logic                 mrs_update_rdy,
  output logic [3:0]           ref_pend
);
  typedef enum logic [2:0] {IDLE, INIT, ACT, RW, WAIT, REF, UPD} state_t;
  localparam logic [CNT_W-1:0] RRD_M1  = CNT_W'(T_RRD - 1);
  localparam logic [CNT_W-1:0] RCD_M1  = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] RFC_M1  = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] REFI_M1 = CNT_W'(T_REFI - 1);
  localparam logic [CNT_W-1:0] MOD_M1  = CNT_W'(T_MOD - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [3:0]       MAXP    = 4'(MAX_POSTPONE);
  localparam logic [4:0]       NB      = 5'(NUM_BANKS);
  state_t state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d, refi_q, refi_d;
  logic refi_run_q, refi_run_d, upd_q, upd_d;
  logic [4:0] bidx_q, bidx_d;
  logic [3:0] ref_pend_q, ref_pend_d, act_bank_q, act_bank_d;
  logic [NUM_BANKS-1:0] bank_open_q, bank_open_d;
  logic busy_q, busy_d, rw_proc_q, rw_proc_d, act_cmd_q, act_cmd_d;
  logic ref_cmd_q, ref_cmd_d, mrs_rdy_q, mrs_rdy_d;
  logic tick, dec, inc, force_ref, enter_act;
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q + ONE;
    bidx_d      = bidx_q;
    bank_open_d = bank_open_q;
    act_cmd_d   = 1'b0;
    act_bank_d  = 4'd0;
    ref_cmd_d   = 1'b0;
    mrs_rdy_d   = 1'b0;
    enter_act   = 1'b0;
    refi_run_d  = refi_run_q;
    tick        = refi_run_q && refi_q == REFI_M1;
    refi_d      = refi_run_q ? (tick ? '0 : refi_q + ONE) : '0;
    dec         = state_q == REF && tmr_q == RFC_M1;
    inc         = tick && (ref_pend_q != MAXP || dec);
    ref_pend_d  = ref_pend_q + 4'(inc) - 4'(dec);
    force_ref   = ref_pend_q == MAXP;
    upd_d       = upd_q | (mrs_update && state_q != IDLE && state_q != INIT);
    case (state_q)
      IDLE: state_d = INIT;
      INIT: enter_act = ini_done;
      ACT: begin
        if (bidx_q < NB) begin
          if (tmr_q == RRD_M1) begin
            if (force_ref || upd_q) state_d = WAIT;
            else begin
              act_cmd_d  = 1'b1;
              act_bank_d = bidx_q[3:0];
              for (int b = 0; b < NUM_BANKS; b++) if (5'(b) == bidx_q) bank_open_d[b] = 1'b1;
              bidx_d     = bidx_q + 5'd1;
              tmr_d      = '0;
            end
          end
        end else if (tmr_q == RCD_M1) state_d = RW;
      end
      RW: if (force_ref || (ref_pend_q != 4'd0 && !rw_req) || upd_q) state_d = WAIT;
      WAIT: begin
        if (rw_idle) begin
          if (ref_pend_q != 4'd0) begin
            state_d   = REF;
            ref_cmd_d = 1'b1;
            tmr_d     = '0;
          end else if (upd_q) begin
            state_d   = UPD;
            mrs_rdy_d = 1'b1;
            upd_d     = 1'b0;
            tmr_d     = '0;
          end else enter_act = 1'b1;
        end
      end
      REF: begin
        // keep draining owed refreshes back-to-back before reopening banks
        if (dec) begin
          if (ref_pend_d != 4'd0) begin
            ref_cmd_d = 1'b1;
            tmr_d     = '0;
          end else begin
            bank_open_d = '0;
            enter_act   = 1'b1;
          end
        end
      end
      UPD: if (tmr_q == MOD_M1) state_d = RW;
      default: state_d = IDLE;
    endcase
    if (enter_act) begin
      state_d        = ACT;
      act_cmd_d      = 1'b1;
      act_bank_d     = 4'd0;
      bank_open_d[0] = 1'b1;
      bidx_d         = 5'd1;
      tmr_d          = '0;
      refi_run_d     = 1'b1;
    end
    busy_d    = state_d == REF || state_d == UPD;
    rw_proc_d = state_d == RW;
  end
  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      refi_q      <= '0;
      refi_run_q  <= 1'b0;
      upd_q       <= 1'b0;
      bidx_q      <= 5'd0;
      ref_pend_q  <= 4'd0;
      act_bank_q  <= 4'd0;
      bank_open_q <= '0;
      busy_q      <= 1'b0;
      rw_proc_q   <= 1'b0;
      act_cmd_q   <= 1'b0;
      ref_cmd_q   <= 1'b0;
      mrs_rdy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      refi_q      <= refi_d;
      refi_run_q  <= refi_run_d;
      upd_q       <= upd_d;
      bidx_q      <= bidx_d;
      ref_pend_q  <= ref_pend_d;
      act_bank_q  <= act_bank_d;
      bank_open_q <= bank_open_d;
      busy_q      <= busy_d;
      rw_proc_q   <= rw_proc_d;
      act_cmd_q   <= act_cmd_d;
      ref_cmd_q   <= ref_cmd_d;
      mrs_rdy_q   <= mrs_rdy_d;
    end
  end
  assign state          = state_q;
  assign busy           = busy_q;
  assign rw_proc        = rw_proc_q;
  assign act_cmd        = act_cmd_q;
  assign act_bank       = act_bank_q;
  assign bank_open      = bank_open_q;
  assign ref_cmd        = ref_cmd_q;
  assign mrs_update_rdy = mrs_rdy_q;
  assign ref_pend       = ref_pend_q;
endmodule

// File: tb/tb_ctrl_sched_fsm.sv
// tb_ctrl_sched_fsm: scoreboard bench; stimulus queues expected events with cycle gaps, a negedge monitor pops and compares.
module tb_ctrl_sched_fsm;
  localparam int K_S = 0, K_A = 1, K_R = 2, K_M = 3, K_P = 4;
  localparam logic [2:0] S_IDLE = 0, S_INIT = 1, S_ACT = 2, S_RW = 3, S_WAIT = 4, S_REF = 5, S_UPD = 6;
  typedef struct {int k; int v; int gap;} ev_t;
  logic CK_t, reset_n, ini_done, rw_req, rw_idle, mrs_update;
  logic [2:0] state;
  logic busy, rw_proc, act_cmd, ref_cmd, mrs_update_rdy;
  logic [3:0] act_bank, ref_pend;
  logic [3:0] bank_open;
  ev_t exp_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0, last_cyc = 0;
  logic [2:0] prev_state = 3'd0;
  logic [3:0] prev_pend = 4'd0;
  ctrl_sched_fsm #(.NUM_BANKS(4), .T_RRD(2), .T_RCD(3), .T_RFC(10), .T_REFI(100),
                   .T_MOD(5), .MAX_POSTPONE(3), .CNT_W(16)) dut (
    .CK_t(CK_t), .reset_n(reset_n), .ini_done(ini_done), .rw_req(rw_req), .rw_idle(rw_idle),
    .mrs_update(mrs_update), .state(state), .busy(busy), .rw_proc(rw_proc), .act_cmd(act_cmd),
    .act_bank(act_bank), .bank_open(bank_open), .ref_cmd(ref_cmd), .mrs_update_rdy(mrs_update_rdy),
    .ref_pend(ref_pend));
  initial CK_t = 1'b0;
  always #5 CK_t = ~CK_t;
  task automatic check(input bit ok, input string nm, input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic push(input int k, input int v, input int g);
    ev_t e;
    e.k = k; e.v = v; e.gap = g;
    exp_q.push_back(e);
  endtask
  task automatic push_act(input int g, input bit with_p0);
    push(K_S, S_ACT, g);
    push(K_A, 0, 0);
    if (with_p0) push(K_P, 0, 0);
    push(K_A, 1, 2);
    push(K_A, 2, 2);
    push(K_A, 3, 2);
    push(K_S, S_RW, 3);
  endtask
  task automatic ev(input int k, input int v);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d at cycle %0d, expected none", k, v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.k != k || e.v != v || (e.gap >= 0 && cyc - last_cyc != e.gap)) begin
        n_fail++;
        $display("FAIL event: got kind=%0d val=%0d gap=%0d expected kind=%0d val=%0d gap=%0d",
                 k, v, cyc - last_cyc, e.k, e.v, e.gap);
      end
    end
    last_cyc = cyc;
  endtask
  always @(negedge CK_t) begin
    cyc++;
    check(busy == (state == S_REF || state == S_UPD), "busy_vs_state", int'(busy), int'(state == S_REF || state == S_UPD));
    check(rw_proc == (state == S_RW), "rw_proc_vs_state", int'(rw_proc), int'(state == S_RW));
    check(!ref_cmd || state == S_REF, "ref_cmd_outside_ref", int'(state), int'(S_REF));
    check(!act_cmd || state == S_ACT, "act_cmd_outside_act", int'(state), int'(S_ACT));
    if (state != prev_state) ev(K_S, int'(state));
    if (act_cmd) ev(K_A, int'(act_bank));
    if (ref_cmd) ev(K_R, 0);
    if (mrs_update_rdy) ev(K_M, 0);
    if (ref_pend != prev_pend) ev(K_P, int'(ref_pend));
    prev_state = state;
    prev_pend  = ref_pend;
  end
  task automatic wait_state(input logic [2:0] s, input int lim, input string nm);
    int i;
    for (i = 0; i < lim; i++) begin
      @(posedge CK_t); #1;
      if (state == s) break;
    end
    if (i == lim) check(1'b0, nm, int'(state), int'(s));
  endtask
  task automatic wait_pend(input logic [3:0] p, input int lim, input string nm);
    int i;
    for (i = 0; i < lim; i++) begin
      @(posedge CK_t); #1;
      if (ref_pend == p) break;
    end
    if (i == lim) check(1'b0, nm, int'(ref_pend), int'(p));
  endtask
  task automatic check_zero(input string tag);
    check(state == 3'd0, {tag, "_state"}, int'(state), 0);
    check(!busy && !rw_proc, {tag, "_busy_rwproc"}, int'({busy, rw_proc}), 0);
    check(!act_cmd && act_bank == 4'd0, {tag, "_act"}, int'({act_cmd, act_bank}), 0);
    check(!ref_cmd && !mrs_update_rdy, {tag, "_ref_mrs"}, int'({ref_cmd, mrs_update_rdy}), 0);
    check(ref_pend == 4'd0, {tag, "_ref_pend"}, int'(ref_pend), 0);
    check(bank_open == 4'd0, {tag, "_bank_open"}, int'(bank_open), 0);
  endtask
  initial begin
    reset_n = 1'b1; ini_done = 1'b0; rw_req = 1'b0; rw_idle = 1'b1; mrs_update = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge CK_t);
    #1 check_zero("reset");
    push(K_S, S_INIT, -1);
    push_act(-1, 1'b0);
    reset_n = 1'b1;
    repeat (4) @(posedge CK_t);
    #1 ini_done = 1'b1;
    wait_state(S_RW, 50, "timeout_first_rw");
    check(bank_open == 4'hF, "bank_open_all", int'(bank_open), 15);
    // opportunistic refresh at the first tick with no RW traffic
    push(K_P, 1, 91); push(K_S, S_WAIT, 1); push(K_S, S_REF, 1); push(K_R, 0, 0);
    push_act(10, 1'b1);
    wait_state(S_REF, 200, "timeout_ref1");
    wait_state(S_RW, 100, "timeout_rw2");
    rw_req = 1'b1;
    // postponed refreshes saturate at 3, then a forced drain burst
    push(K_P, 1, 79); push(K_P, 2, 100); push(K_P, 3, 100);
    push(K_S, S_WAIT, 1); push(K_S, S_REF, 1); push(K_R, 0, 0);
    push(K_R, 0, 10); push(K_P, 2, 0); push(K_R, 0, 10); push(K_P, 1, 0);
    push_act(10, 1'b1);
    wait_state(S_REF, 400, "timeout_ref_forced");
    wait_state(S_RW, 100, "timeout_rw3");
    check(bank_open == 4'hF, "bank_open_after_drain", int'(bank_open), 15);
    // MRS update while a refresh is owed: refresh first, ACT aborts at next slot, then UPD
    push(K_P, 1, 59); push(K_S, S_WAIT, 2); push(K_S, S_REF, 1); push(K_R, 0, 0);
    push(K_S, S_ACT, 10); push(K_A, 0, 0); push(K_P, 0, 0);
    push(K_S, S_WAIT, 2); push(K_S, S_UPD, 1); push(K_M, 0, 0); push(K_S, S_RW, 5);
    wait_pend(4'd1, 200, "timeout_pend1");
    mrs_update = 1'b1;
    @(posedge CK_t);
    #1 mrs_update = 1'b0;
    wait_state(S_UPD, 100, "timeout_upd");
    wait_state(S_RW, 50, "timeout_rw_after_upd");
    check(bank_open == 4'h1, "bank_open_after_abort", int'(bank_open), 1);
    // WAIT stalled by rw_idle=0, then reset during REF with two owed
    rw_idle = 1'b0;
    push(K_P, 1, 79); push(K_S, S_WAIT, 1); push(K_P, 2, 99); push(K_S, S_REF, 1); push(K_R, 0, 0);
    wait_pend(4'd1, 200, "timeout_pend1b");
    rw_req = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge CK_t); #1;
      check(state == S_WAIT && !busy && !rw_proc && !ref_cmd, "wait_stall",
            int'({state, busy, rw_proc, ref_cmd}), int'({S_WAIT, 3'b000}));
    end
    wait_pend(4'd2, 200, "timeout_pend2");
    rw_idle = 1'b1;
    repeat (3) @(posedge CK_t);
    #1 check(state == S_REF && ref_pend == 4'd2 && busy, "mid_ref", int'({state, ref_pend, busy}),
             int'({S_REF, 4'd2, 1'b1}));
    push(K_S, S_IDLE, -1); push(K_P, 0, 0);
    reset_n = 1'b0;
    #1 check_zero("async_reset");
    ini_done = 1'b0;
    repeat (2) @(posedge CK_t);
    push(K_S, S_INIT, -1);
    #1 reset_n = 1'b1;
    wait_state(S_INIT, 5, "timeout_init_after_reset");
    repeat (3) @(posedge CK_t);
    #1 check(exp_q.size() == 0, "events_outstanding", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
